// File: rtl/sdram_req_responder.sv
// Target side of the 16-bit SDRAM rd/wr/rdy/ack handshake, bridging one halfword
// transfer at a time onto a req/gnt/rvalid memory port with timeout and error flagging.
module sdram_req_responder #(
    parameter int          ADDR_W         = 24,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] TIMEOUT_RDATA  = 16'hDEAD
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              sdram_rd_i,
    input  logic              sdram_wr_i,
    output logic              sdram_rdy_o,
    input  logic              sdram_ack_i,
    input  logic [ADDR_W-1:0] sdram_addr_x16_i,
    input  logic [15:0]       sdram_wdata_i,
    input  logic [1:0]        sdram_wmask_i,
    output logic [15:0]       sdram_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic [1:0]        mem_be_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [15:0]       mem_rdata_i,

    output logic              protocol_err_o
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RWAIT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic [CNT_W-1:0] tmo_next;

    // Timeout fires on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign tmo_hit  = (tmo_cnt >= CNT_LAST);
    assign tmo_next = (tmo_cnt == CNT_MAX) ? CNT_MAX : tmo_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            sdram_rdy_o    <= 1'b1;
            sdram_rdata_o  <= 16'h0000;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= 16'h0000;
            mem_be_o       <= 2'b00;
            protocol_err_o <= 1'b0;
            tmo_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sdram_rd_i || sdram_wr_i) begin
                        state       <= REQ;
                        sdram_rdy_o <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= sdram_wr_i;
                        mem_addr_o  <= sdram_addr_x16_i;
                        mem_wdata_o <= sdram_wdata_i;
                        mem_be_o    <= sdram_wr_i ? sdram_wmask_i : 2'b11;
                        tmo_cnt     <= '0;
                        // Simultaneous rd and wr: executed as a write, but flagged.
                        if (sdram_rd_i && sdram_wr_i) begin
                            protocol_err_o <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    tmo_cnt <= tmo_next;
                    if (sdram_ack_i) begin
                        protocol_err_o <= 1'b1;
                    end
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            state       <= DONE;
                            sdram_rdy_o <= 1'b1;
                        end else begin
                            state <= RWAIT;
                        end
                    end else if (tmo_hit) begin
                        state          <= DONE;
                        mem_req_o      <= 1'b0;
                        sdram_rdy_o    <= 1'b1;
                        protocol_err_o <= 1'b1;
                        if (!mem_we_o) begin
                            sdram_rdata_o <= TIMEOUT_RDATA;
                        end
                    end
                end

                RWAIT: begin
                    tmo_cnt <= tmo_next;
                    if (sdram_ack_i) begin
                        protocol_err_o <= 1'b1;
                    end
                    if (mem_rvalid_i) begin
                        state         <= DONE;
                        sdram_rdy_o   <= 1'b1;
                        sdram_rdata_o <= mem_rdata_i;
                    end else if (tmo_hit) begin
                        state          <= DONE;
                        sdram_rdy_o    <= 1'b1;
                        sdram_rdata_o  <= TIMEOUT_RDATA;
                        protocol_err_o <= 1'b1;
                    end
                end

                DONE: begin
                    // The still-held rd/wr of the finished request is ignored here.
                    if (sdram_ack_i) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    sdram_rdy_o <= 1'b1;
                    mem_req_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_responder.sv
// Scoreboard bench for sdram_req_responder: backend model with configurable grant and
// read-data delay; expected backend requests and read data are queued at stimulus time.
module tb_sdram_req_responder;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sdram_rd, sdram_wr, sdram_rdy, sdram_ack;
    logic [ADDR_W-1:0] sdram_addr;
    logic [15:0]       sdram_wdata, sdram_rdata;
    logic [1:0]        sdram_wmask;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid, protocol_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata, mem_rdata;
    logic [1:0]        mem_be;

    always #5 clk = ~clk;

    sdram_req_responder #(
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(255),
        .TIMEOUT_RDATA(16'hDEAD)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .sdram_rd_i(sdram_rd),
        .sdram_wr_i(sdram_wr),
        .sdram_rdy_o(sdram_rdy),
        .sdram_ack_i(sdram_ack),
        .sdram_addr_x16_i(sdram_addr),
        .sdram_wdata_i(sdram_wdata),
        .sdram_wmask_i(sdram_wmask),
        .sdram_rdata_o(sdram_rdata),
        .mem_req_o(mem_req),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_be_o(mem_be),
        .mem_gnt_i(mem_gnt),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata),
        .protocol_err_o(protocol_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backend model: combinational grant, read data after rv_delay cycles.
    logic        gnt_en;
    int          rv_delay;
    logic        init_mem;
    logic        pend;
    int          rv_cnt;
    logic [7:0]  rd_idx;
    logic [15:0] mem [256];

    assign mem_gnt    = mem_req && gnt_en;
    assign mem_rvalid = pend && (rv_cnt == 0);
    assign mem_rdata  = mem_rvalid ? mem[rd_idx] : 16'h0000;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h20] <= 16'h1234;
            mem[8'h21] <= 16'h5678;
            pend       <= 1'b0;
            rv_cnt     <= 0;
            rd_idx     <= 8'h00;
        end else if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (rv_cnt == 0) pend <= 1'b0;
                else             rv_cnt <= rv_cnt - 1;
            end
            if (mem_req && mem_gnt) begin
                if (mem_we) begin
                    if (mem_be[0]) mem[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
                    if (mem_be[1]) mem[mem_addr[7:0]][15:8] <= mem_wdata[15:8];
                end else begin
                    pend   <= 1'b1;
                    rv_cnt <= rv_delay - 1;
                    rd_idx <= mem_addr[7:0];
                end
            end
        end
    end

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       wdata;
        logic [1:0]        be;
    } mreq_t;

    mreq_t       exp_mem[$];
    logic [15:0] exp_rd[$];
    logic [15:0] last_rdata;

    // Backend request monitor: each granted request is compared with the queued one.
    always @(negedge clk) begin
        mreq_t e;
        if (rst_n && mem_req && mem_gnt) begin
            if (exp_mem.size() == 0) begin
                check("mem_unexpected_req", 32'd1, 32'd0);
            end else begin
                e = exp_mem.pop_front();
                check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                check("mem_addr", {8'd0, mem_addr}, {8'd0, e.addr});
                check("mem_be", {30'd0, mem_be}, {30'd0, e.be});
                if (e.we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
            end
        end
    end

    task automatic xfer(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [15:0] wdata, input logic [1:0] wmask,
                        input logic [15:0] rdata_exp, input int lat_exp, input int ack_at,
                        input bit expect_mem);
        int k;
        bit done;
        logic [15:0] seen;
        if (expect_mem) exp_mem.push_back('{we: wr, addr: addr, wdata: wdata,
                                            be: (wr ? wmask : 2'b11)});
        if (rd && !wr) exp_rd.push_back(rdata_exp);
        sdram_rd    = rd;
        sdram_wr    = wr;
        sdram_addr  = addr;
        sdram_wdata = wdata;
        sdram_wmask = wmask;
        k = 0;
        done = 0;
        while (!done && k < 400) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            sdram_ack = (k == ack_at);
            if (k == 1) begin
                check("rdy_low_after_req", {31'd0, sdram_rdy}, 32'd0);
                check("mem_req_high", {31'd0, mem_req}, 32'd1);
            end
            if (sdram_rdy) done = 1;
        end
        sdram_ack = 1'b0;
        if (!done) begin
            check("rdy_wait_expired", 32'd0, 32'd1);
        end else begin
            check("latency", k, lat_exp);
            if (rd && !wr) begin
                check("rdata", {16'd0, sdram_rdata}, {16'd0, exp_rd.pop_front()});
                last_rdata = sdram_rdata;
            end else begin
                check("rdata_unchanged_by_write", {16'd0, sdram_rdata}, {16'd0, last_rdata});
            end
        end
        seen = sdram_rdata;
        @(posedge clk);
        @(negedge clk);
        check("rdy_held_done", {31'd0, sdram_rdy}, 32'd1);
        check("rdata_stable_done", {16'd0, sdram_rdata}, {16'd0, seen});
        sdram_ack = 1'b1;
        sdram_rd  = 1'b0;
        sdram_wr  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sdram_ack = 1'b0;
        check("rdy_after_ack", {31'd0, sdram_rdy}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 16'h0000;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        init_mem = 1'b1;
        gnt_en = 1'b1;
        rv_delay = 1;
        sdram_rd = 1'b0;
        sdram_wr = 1'b0;
        sdram_ack = 1'b0;
        sdram_addr = '0;
        sdram_wdata = 16'h0000;
        sdram_wmask = 2'b00;
        last_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        init_mem = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset / idle state, ack while idle is harmless
        check("reset_rdy", {31'd0, sdram_rdy}, 32'd1);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_err", {31'd0, protocol_err}, 32'd0);
        check("reset_rdata", {16'd0, sdram_rdata}, 32'd0);
        check("reset_be", {30'd0, mem_be}, 32'd0);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_no_err", {31'd0, protocol_err}, 32'd0);

        // Zero-wait write with low byte enable, then read it back
        xfer(1'b0, 1'b1, 24'h000010, 16'hBEEF, 2'b01, 16'h0000, 2, 0, 1'b1);
        xfer(1'b1, 1'b0, 24'h000010, 16'h0000, 2'b00, 16'h00EF, 3, 0, 1'b1);
        check("write_no_err", {31'd0, protocol_err}, 32'd0);

        // Back-to-back halfword reads with rvalid delay 3
        rv_delay = 3;
        xfer(1'b1, 1'b0, 24'h000020, 16'h0000, 2'b00, 16'h1234, 5, 0, 1'b1);
        xfer(1'b1, 1'b0, 24'h000021, 16'h0000, 2'b00, 16'h5678, 5, 0, 1'b1);
        check("reads_no_err", {31'd0, protocol_err}, 32'd0);

        // Backend never grants: forced completion and sticky error
        gnt_en = 1'b0;
        xfer(1'b1, 1'b0, 24'h000040, 16'h0000, 2'b00, 16'hDEAD, 256, 0, 1'b0);
        check("timeout_err", {31'd0, protocol_err}, 32'd1);
        repeat (5) @(negedge clk);
        check("timeout_err_sticky", {31'd0, protocol_err}, 32'd1);
        gnt_en = 1'b1;
        do_reset();
        check("err_cleared_by_reset", {31'd0, protocol_err}, 32'd0);

        // ack pulsed while waiting for read data
        rv_delay = 5;
        xfer(1'b1, 1'b0, 24'h000021, 16'h0000, 2'b00, 16'h5678, 7, 2, 1'b1);
        check("ack_in_rwait_err", {31'd0, protocol_err}, 32'd1);
        do_reset();

        // rd and wr together: executed as a write, error flagged
        rv_delay = 1;
        check("pre_rdwr_err", {31'd0, protocol_err}, 32'd0);
        xfer(1'b1, 1'b1, 24'h000030, 16'hA5A5, 2'b11, 16'h0000, 2, 0, 1'b1);
        check("rdwr_err", {31'd0, protocol_err}, 32'd1);
        xfer(1'b1, 1'b0, 24'h000020, 16'h0000, 2'b00, 16'h1234, 3, 0, 1'b1);

        // Reset while in RWAIT, then a normal read
        rv_delay = 6;
        exp_mem.push_back('{we: 1'b0, addr: 24'h000021, wdata: 16'h0000, be: 2'b11});
        sdram_rd = 1'b1;
        sdram_addr = 24'h000021;
        repeat (3) @(negedge clk);
        check("rwait_pending_rdy", {31'd0, sdram_rdy}, 32'd0);
        rst_n = 1'b0;
        sdram_rd = 1'b0;
        #1;
        check("midreset_rdy", {31'd0, sdram_rdy}, 32'd1);
        check("midreset_mem_req", {31'd0, mem_req}, 32'd0);
        check("midreset_rdata", {16'd0, sdram_rdata}, 32'd0);
        check("midreset_err", {31'd0, protocol_err}, 32'd0);
        check("midreset_addr", {8'd0, mem_addr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 16'h0000;
        @(negedge clk);
        rv_delay = 1;
        xfer(1'b1, 1'b0, 24'h000030, 16'h0000, 2'b00, 16'hA5A5, 3, 0, 1'b1);
        check("post_reset_no_err", {31'd0, protocol_err}, 32'd0);

        check("mem_queue_drained", exp_mem.size(), 32'd0);
        check("rd_queue_drained", exp_rd.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
